product_accumulator: RTL
========================

// Module: product_accumulator
// PURPOSE
// - Downstream stage of the 4x4 combinational multiplier: consumes its 8-bit product stream, sums N_TERMS products, presents one sum.
// - Forms the accumulate half of a multiply-accumulate datapath.
// - Valid/ready handshake on both sides, so the upstream operand sequencer and the downstream consumer can stall independently.
// PARAMETERS
// - N_TERMS  4   products summed per result; legal range 1..256.
// - PROD_W   8   product input width; matches the multiplier output.
// - ACC_W    10  accumulator and sum width; must be >= PROD_W.
// PORTS
// - clk          in   1        single clock, rising edge
// - rst_n        in   1        asynchronous, active-low reset
// - start        in   1        one-cycle pulse; clears accumulator and begins a frame; honoured only in IDLE
// - product_in   in   PROD_W   unsigned product from the multiplier
// - in_valid     in   1        product_in is valid
// - in_ready     out  1        block accepts a product this cycle
// - sum_out      out  ACC_W    accumulated sum; registered
// - out_valid    out  1        sum_out is valid
// - out_ready    in   1        downstream accepts sum_out
// - busy         out  1        high in ACCUM or DONE
// - ovf          out  1        sticky overflow flag for the frame; present only with ACC_SAT_EN
// BEHAVIOUR
// - Reset (async assert, sync deassert by system): state=IDLE, acc=0, cnt=0, sum_out=0; in_ready, out_valid, busy, ovf all 0.
// - Reset mid-frame aborts the frame; partial sum is discarded.
// - FSM states: IDLE=2'b00, ACCUM=2'b01, DONE=2'b10; 2'b11 returns to IDLE.
// - IDLE
//   - in_ready=0; in_valid is ignored.
//   - start=1: acc<=0, cnt<=0, ovf<=0, next state ACCUM.
// - ACCUM
//   - in_ready=1; transfer when in_valid && in_ready.
//   - Each transfer: acc<=acc+product_in (zero-extended to ACC_W); cnt<=cnt+1.
//   - No transfer: acc and cnt hold.
//   - Transfer with cnt==N_TERMS-1: sum_out<=acc+product_in, next state DONE.
//   - Latency: out_valid rises one cycle after the last accepted product.
// - DONE
//   - out_valid=1, in_ready=0; sum_out stable until accepted.
//   - out_ready=1: next state IDLE, out_valid drops next cycle.
// - start outside IDLE is ignored, including start coinciding with out_ready in DONE.
// - cnt width: $clog2(N_TERMS+1); cnt never exceeds N_TERMS-1.
// - N_TERMS=1: a single transfer moves directly to DONE.
// CONFIGURATION
// - Macro ACC_SAT_EN.
// - Defined: any add whose true sum exceeds 2^ACC_W-1 clamps acc to 2^ACC_W-1 and sets ovf; ovf stays set until the next accepted start or reset; ovf port exists.
// - Undefined: addition wraps modulo 2^ACC_W; no ovf port, no saturation logic.
// STRUCTURE
// - Shared header mult_defs.vh holds: state encodings (ST_IDLE, ST_ACCUM, ST_DONE) and PROD_W default 8, shared with the multiplier and its operand sequencer.
// - One sub-module, acc_adder: combinational ACC_W adder with carry-out and optional clamp, selected by ACC_SAT_EN; the top level keeps the FSM, counter and registers.
// TESTING
// 1. start; products 1,4,9,16 with in_valid held high -> out_valid 1 cycle after 4th transfer; sum_out=30; ovf=0.
// 2. Same frame with in_valid deasserted between products and out_ready held low 5 cycles -> sum_out=30 held stable; exactly one result accepted.
// 3. in_valid=1, product=0xFF in IDLE without start -> in_ready=0, acc unchanged; start issued in ACCUM -> ignored; frame completes normally.
// 4. rst_n pulled low after 2 of 4 products -> all outputs 0 immediately; a new frame of 2,2,2,2 yields sum_out=8.
// 5. ACC_W=8, N_TERMS=2, products 225,225 -> with ACC_SAT_EN: sum_out=255, ovf=1; without ACC_SAT_EN: sum_out=194.
// 6. Back-to-back frames: start pulsed the cycle after out_ready handshake -> second frame sum correct; acc not carried over between frames.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// rtl/product_accumulator_pkg.sv - shared state encodings and defaults for the product accumulator
package product_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam int PROD_W_DEFAULT = 8;

    function automatic int cnt_width(input int n_terms);
        return $clog2(n_terms + 1);
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product input and sum output handshake bundle
interface product_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 10
);
    logic [PROD_W-1:0] product_in;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  sum_out;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output product_in, in_valid, out_ready,
        input  in_ready, sum_out, out_valid
    );

    modport slave (
        input  product_in, in_valid, out_ready,
        output in_ready, sum_out, out_valid
    );
endinterface

// File: rtl/product_accumulator_acc_adder.sv
// rtl/product_accumulator_acc_adder.sv - accumulator adder with carry-out; clamps to all-ones when ACC_SAT_EN is defined
module acc_adder #(
    parameter int ACC_W  = 10,
    parameter int PROD_W = 8
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W:0] full;

    assign full  = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
    assign carry = full[ACC_W];

`ifdef ACC_SAT_EN
    assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign sum = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums N_TERMS products per frame; ACC_SAT_EN adds saturation and the ovf port
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int PROD_W  = PROD_W_DEFAULT,
    parameter int ACC_W   = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    product_accumulator_if.slave bus
`ifdef ACC_SAT_EN
    ,
    output logic ovf
`endif
);
    localparam int CNT_W = cnt_width(N_TERMS);

    state_t             state;
    state_t             next_state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic [CNT_W-1:0]   cnt;
    logic               xfer;
    logic               last;

    assign xfer = (state == ST_ACCUM) && bus.in_valid;
    assign last = (cnt == CNT_W'(N_TERMS - 1));

    acc_adder #(.ACC_W(ACC_W), .PROD_W(PROD_W)) u_adder (
        .a     (acc),
        .b     (bus.product_in),
        .sum   (add_sum),
        .carry (add_carry)
    );

`ifndef ACC_SAT_EN
    logic unused_carry;
    assign unused_carry = add_carry;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // start is only looked at in IDLE, so a start alongside out_ready in DONE is dropped
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:  next_state = start ? ST_ACCUM : ST_IDLE;
            ST_ACCUM: next_state = (xfer && last) ? ST_DONE : ST_ACCUM;
            ST_DONE:  next_state = bus.out_ready ? ST_IDLE : ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ST_ACCUM);
        bus.out_valid = (state == ST_DONE);
        busy          = (state == ST_ACCUM) || (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            bus.sum_out <= '0;
`ifdef ACC_SAT_EN
            ovf         <= 1'b0;
`endif
        end else if (state == ST_IDLE && start) begin
            acc <= '0;
            cnt <= '0;
`ifdef ACC_SAT_EN
            ovf <= 1'b0;
`endif
        end else if (xfer) begin
            acc <= add_sum;
            cnt <= last ? '0 : cnt + CNT_W'(1);
            if (last) bus.sum_out <= add_sum;
`ifdef ACC_SAT_EN
            ovf <= ovf | add_carry;
`endif
        end
    end
endmodule
